// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control sequencer (IF/ID/EXE/MEM/WB) with memory ready handshakes and sticky HALT/FAULT.
// Define MCFSM_TIMEOUT_EN to build the memory-wait watchdog that faults after TMO_CYC stalled cycles.
module multicycle_ctrl_fsm #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int TMO_CYC = 15,
    parameter int CNT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               DataMemRW,
    output logic               ALUSrcB,
    output logic               ALUM2Reg,
    output logic               RegWre,
    output logic               WrRegData,
    output logic [1:0]         ExtSel,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegOut,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               fault
);

    if (TMO_CYC < 1 || TMO_CYC > (2**CNT_W) - 1) begin : g_bad_tmo
        $error("TMO_CYC must fit in the CNT_W-bit wait counter");
    end

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic   is_r, is_imm, is_lw, is_sw, is_beq, is_j, is_jr, is_jal, is_halt, is_legal;
    logic   tmo;

    function automatic logic [ALUOP_W-1:0] alu_sel(input logic [OP_W-1:0] op);
        logic [ALUOP_W-1:0] sel;
        sel = ALUOP_W'(3'b000);
        if (op == OP_SUB || op == OP_BEQ)      sel = ALUOP_W'(3'b001);
        else if (op == OP_SLT)                 sel = ALUOP_W'(3'b010);
        else if (op == OP_OR || op == OP_ORI)  sel = ALUOP_W'(3'b011);
        else if (op == OP_AND)                 sel = ALUOP_W'(3'b100);
        return sel;
    endfunction

    always_comb begin
        is_r     = opcode inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT};
        is_imm   = opcode inside {OP_ADDI, OP_ORI};
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_jr    = (opcode == OP_JR);
        is_jal   = (opcode == OP_JAL);
        is_halt  = (opcode == OP_HALT);
        is_legal = is_r | is_imm | is_lw | is_sw | is_beq | is_j | is_jr | is_jal | is_halt;
    end

`ifdef MCFSM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo = (cnt_q == CNT_W'(TMO_CYC));

    // Counts only consecutive stalled cycles; any ready, timeout or state change restarts it.
    always_comb begin
        cnt_d = '0;
        if (((state_q == S_IF) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready)) begin
            if (!tmo) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        DataMemRW = 1'b0;
        ALUSrcB   = 1'b0;
        ALUM2Reg  = 1'b0;
        RegWre    = 1'b0;
        WrRegData = 1'b0;
        ExtSel    = 2'b00;
        PCSrc     = 2'b00;
        RegOut    = 2'b00;
        ALUOp     = '0;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                // IR must not load while reset is held, even if memory says ready.
                if (imem_ready) begin
                    IRWre   = ~RST;
                    state_d = S_ID;
                end else if (tmo) begin
                    state_d = S_FAULT;
                end
            end
            S_ID: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    state_d = S_FAULT;
                end else if (is_j || is_jr || is_jal) begin
                    PCSrc   = is_jr ? 2'b10 : 2'b11;
                    PCWre   = 1'b1;
                    RegWre  = is_jal;
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                ALUSrcB = is_imm | is_lw | is_sw;
                ExtSel  = (opcode == OP_ORI) ? 2'b00 : 2'b01;
                ALUOp   = alu_sel(opcode);
                if (is_beq) begin
                    PCSrc   = {1'b0, zero};
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                DataMemRW = is_sw;
                if (dmem_ready) begin
                    PCWre   = is_sw;
                    state_d = is_sw ? S_IF : S_WB;
                end else if (tmo) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                WrRegData = 1'b1;
                RegOut    = is_r ? 2'b10 : 2'b01;
                ALUM2Reg  = is_lw;
                ALUOp     = alu_sel(opcode);
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    assign InsMemRW = 1'b0;
    assign state    = state_q;
    assign fault    = (state_q == S_FAULT);

endmodule
